mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 186 ++++++++++++++++++
 tb/tb_mem_access.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`timescale 1ns / 1ps
// mem_access: bridges the datapath MAR/MDR to an asynchronous SRAM and to a
// small memory-mapped I/O space (switches in, hex display out).
//
// Ports
//   clk, reset_n       single clock, asynchronous active-low reset
//   mem_en, we         access request and direction (1 = write)
//   MAR, MDR           address and write data from the datapath
//   MDR_In             registered read data back to the datapath
//   R                  one-cycle ready pulse at transfer completion
//   sram_addr          SRAM address, {4'b0, latched MAR}
//   sram_dq_out        SRAM write data (latched MDR)
//   sram_dq_in         SRAM read data
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes
//   switches           I/O read source (address 16'hFFFF)
//   hex_out            I/O write target (address 16'hFFFF)
//
// Transfer timing, counted in cycles after the acceptance edge:
//   I/O  : DONE in cycle 1.
//   SRAM : SETUP in cycle 1, ACCESS in cycles 2..WAIT_CYCLES+1, DONE in
//          cycle WAIT_CYCLES+2.
// Every output is a flop; the strobes are computed from the next state so
// they line up with the state they belong to.
module mem_access #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_en,
  input  logic        we,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  input  logic [15:0] switches,
  output logic [15:0] hex_out
);

  localparam logic [15:0] IoAddr   = 16'hFFFF;
  // ACCESS counts down from WAIT_CYCLES-1 to 0, so it lasts WAIT_CYCLES cycles.
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;

  logic        accept;
  logic        io_hit;
  logic        last_access;
  logic        on_bus_d;

  logic [15:0] mdr_in_q, mdr_in_d;
  logic [15:0] hex_q, hex_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        r_q, r_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  assign io_hit = (MAR == IoAddr);

  // Next-state logic. mem_en only matters in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    accept      = 1'b0;
    last_access = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_en) begin
          accept  = 1'b1;
          we_d    = we;
          state_d = io_hit ? StDone : StSetup;
        end
      end
      StSetup: begin
        cnt_d   = WaitLast;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          last_access = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output next values. Strobes follow the state being entered so that the
  // registered pins are valid for the whole of that state.
  always_comb begin
    on_bus_d = (state_d == StSetup) || (state_d == StAccess);
    ce_n_d   = ~on_bus_d;
    oe_n_d   = ~(on_bus_d && !we_d);
    we_n_d   = ~((state_d == StAccess) && we_d);
    r_d      = (state_d == StDone);

    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    if (accept && !io_hit) begin
      addr_d   = {4'b0000, MAR};
      dq_out_d = MDR;
    end

    // I/O accesses complete on the acceptance edge itself, so they take the
    // live inputs, which are the values being latched on that edge.
    mdr_in_d = mdr_in_q;
    if (accept && io_hit && !we) begin
      mdr_in_d = switches;
    end else if (last_access && !we_q) begin
      mdr_in_d = sram_dq_in;
    end

    hex_d = hex_q;
    if (accept && io_hit && we) begin
      hex_d = MDR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdr_in_q <= 16'h0000;
      hex_q    <= 16'h0000;
      addr_q   <= 20'h00000;
      dq_out_q <= 16'h0000;
      r_q      <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      mdr_in_q <= mdr_in_d;
      hex_q    <= hex_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      r_q      <= r_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
    end
  end

  assign MDR_In      = mdr_in_q;
  assign hex_out     = hex_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign R           = r_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns / 1ps
// Scoreboard bench for mem_access: stimulus pushes transaction-level
// expectations, a negedge monitor checks pins cycle by cycle and pops on R.
module tb_mem_access;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_en1 = 1'b0;
  logic        mem_en15 = 1'b0;
  logic        we = 1'b0;
  logic [15:0] MAR = 16'h0;
  logic [15:0] MDR = 16'h0;
  logic [15:0] sram_dq_in = 16'h0;
  logic [15:0] switches = 16'h0;

  logic [15:0] mdr_in, hex, dq_out;
  logic [19:0] addr;
  logic        r, ce_n, oe_n, we_n;

  logic [15:0] mdr1, hex1, dq1, mdr15, hex15, dq15;
  logic [19:0] addr1, addr15;
  logic        r1, ce1, oe1, wen1, r15, ce15, oe15, wen15;

  mem_access #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en), .we(we), .MAR(MAR), .MDR(MDR),
    .MDR_In(mdr_in), .R(r), .sram_addr(addr), .sram_dq_out(dq_out),
    .sram_dq_in(sram_dq_in), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .switches(switches), .hex_out(hex)
  );

  mem_access #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en1), .we(we), .MAR(MAR), .MDR(MDR),
    .MDR_In(mdr1), .R(r1), .sram_addr(addr1), .sram_dq_out(dq1),
    .sram_dq_in(sram_dq_in), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(wen1),
    .switches(switches), .hex_out(hex1)
  );

  mem_access #(.WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en15), .we(we), .MAR(MAR), .MDR(MDR),
    .MDR_In(mdr15), .R(r15), .sram_addr(addr15), .sram_dq_out(dq15),
    .sram_dq_in(sram_dq_in), .sram_ce_n(ce15), .sram_oe_n(oe15), .sram_we_n(wen15),
    .switches(switches), .hex_out(hex15)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected transaction: acc is the posedge count of the acceptance edge.
  typedef struct {
    int          acc;
    logic        io;
    logic        w;
    logic [19:0] addr;
    logic [15:0] dq;
    logic [15:0] mdr_in;
    logic [15:0] hex;
  } exp_t;

  exp_t sb[$];

  // Reference state of the two architectural outputs.
  logic [15:0] ref_mdr = 16'h0;
  logic [15:0] ref_hex = 16'h0;
  // Values the monitor expects to see held between completions.
  logic [15:0] mon_mdr = 16'h0;
  logic [15:0] mon_hex = 16'h0;

  exp_t cur;
  int   k, lat;

  always @(negedge clk) begin
    if (sb.size() > 0 && cyc >= sb[0].acc) begin
      cur = sb[0];
      k   = cyc - cur.acc + 1;
      lat = cur.io ? 1 : W + 2;
      if (k >= lat) begin
        chk("r_done", 32'(r), 32'd1);
        chk("mdr_in_done", 32'(mdr_in), 32'(cur.mdr_in));
        chk("hex_done", 32'(hex), 32'(cur.hex));
        chk("strobes_done", 32'({ce_n, oe_n, we_n}), 32'h7);
        mon_mdr = cur.mdr_in;
        mon_hex = cur.hex;
        void'(sb.pop_front());
      end else begin
        chk("r_busy", 32'(r), 32'd0);
        chk("ce_n_busy", 32'(ce_n), 32'd0);
        chk("oe_n_busy", 32'(oe_n), 32'(cur.w));
        chk("we_n_busy", 32'(we_n), 32'(!(k >= 2 && cur.w)));
        chk("addr_busy", 32'(addr), 32'(cur.addr));
        chk("dq_out_busy", 32'(dq_out), 32'(cur.dq));
        chk("mdr_in_hold", 32'(mdr_in), 32'(mon_mdr));
        chk("hex_hold", 32'(hex), 32'(mon_hex));
      end
    end else begin
      chk("r_idle", 32'(r), 32'd0);
      chk("strobes_idle", 32'({ce_n, oe_n, we_n}), 32'h7);
      chk("mdr_in_idle", 32'(mdr_in), 32'(mon_mdr));
      chk("hex_idle", 32'(hex), 32'(mon_hex));
    end
  end

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] dq, input logic [15:0] sw, input int acc);
    exp_t e;
    we         = w;
    MAR        = a;
    MDR        = d;
    sram_dq_in = dq;
    switches   = sw;
    mem_en     = 1'b1;
    e.acc  = acc;
    e.io   = (a == 16'hFFFF);
    e.w    = w;
    e.addr = {4'h0, a};
    e.dq   = d;
    if (e.io) begin
      if (w) ref_hex = d;
      else   ref_mdr = sw;
    end else if (!w) begin
      ref_mdr = dq;
    end
    e.mdr_in = ref_mdr;
    e.hex    = ref_hex;
    sb.push_back(e);
  endtask

  // Latched inputs must not matter once accepted; sram_dq_in is left alone.
  task automatic scramble();
    MAR      = 16'($urandom);
    MDR      = 16'($urandom);
    we       = 1'($urandom);
    switches = 16'($urandom);
  endtask

  task automatic wait_r();
    int n = 0;
    while (!r && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL r_timeout: got R=0 after %0d cycles, expected a pulse", n);
    end
  endtask

  task automatic finish_xfer();
    @(negedge clk);
    scramble();
    wait_r();
    mem_en = 1'b0;
  endtask

  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] dq, input logic [15:0] sw);
    @(negedge clk);
    issue(w, a, d, dq, sw, cyc + 1);
    finish_xfer();
  endtask

  // mem_en stays high through DONE: the second request is taken in the
  // IDLE cycle that follows, two edges after the DONE negedge.
  task automatic xfer_b2b();
    @(negedge clk);
    issue(1'b1, 16'h1111, 16'hABCD, 16'h0, 16'h0, cyc + 1);
    @(negedge clk);
    scramble();
    wait_r();
    issue(1'b0, 16'h2222, 16'h0, 16'h0F0F, 16'h0, cyc + 2);
    @(negedge clk);
    finish_xfer();
  endtask

  task automatic sweep(input int sel, input int lat_exp, input logic [15:0] dq);
    int   acc;
    int   n;
    logic rr;
    @(negedge clk);
    MAR        = 16'h0100;
    we         = 1'b0;
    sram_dq_in = dq;
    if (sel == 15) mem_en15 = 1'b1;
    else           mem_en1 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    mem_en1  = 1'b0;
    mem_en15 = 1'b0;
    n  = 0;
    rr = (sel == 15) ? r15 : r1;
    while (!rr && n < 40) begin
      @(negedge clk);
      n++;
      rr = (sel == 15) ? r15 : r1;
    end
    chk("sweep_latency", 32'(cyc - acc + 1), 32'(lat_exp));
    chk("sweep_mdr_in", 32'((sel == 15) ? mdr15 : mdr1), 32'(dq));
  endtask

  logic        rw;
  logic [15:0] ra, rd, rdq, rsw;

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_r", 32'(r), 32'd0);
    chk("reset_mdr_in", 32'(mdr_in), 32'd0);
    chk("reset_hex", 32'(hex), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_dq_out", 32'(dq_out), 32'd0);
    chk("reset_strobes", 32'({ce_n, oe_n, we_n}), 32'h7);
    #2 reset_n = 1'b1;

    xfer(1'b0, 16'h3000, 16'h0000, 16'hBEEF, 16'h0000);
    xfer(1'b1, 16'h0042, 16'h1234, 16'h7777, 16'h0000);
    xfer(1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000);
    xfer(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h5A5A);
    xfer_b2b();

    for (int i = 0; i < 30; i++) begin
      rw  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rd  = 16'($urandom);
      rdq = 16'($urandom);
      rsw = 16'($urandom);
      xfer(rw, ra, rd, rdq, rsw);
    end

    // Reset in the middle of ACCESS of a write.
    @(negedge clk);
    issue(1'b1, 16'h0123, 16'hCAFE, 16'h0, 16'h0, cyc + 1);
    @(negedge clk);
    scramble();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    mem_en  = 1'b0;
    sb.delete();
    ref_mdr = 16'h0;
    ref_hex = 16'h0;
    mon_mdr = 16'h0;
    mon_hex = 16'h0;
    #1;
    chk("async_we_n", 32'(we_n), 32'd1);
    chk("async_ce_n", 32'(ce_n), 32'd1);
    chk("async_oe_n", 32'(oe_n), 32'd1);
    chk("async_r", 32'(r), 32'd0);
    chk("async_mdr_in", 32'(mdr_in), 32'd0);
    chk("async_hex", 32'(hex), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    issue(1'b0, 16'h4444, 16'h0, 16'h600D, 16'h0, cyc + 1);
    finish_xfer();

    sweep(1, 3, 16'h1357);
    sweep(15, 17, 16'h2468);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
